// File: rtl/gpio_rx_pkg.sv
// gpio_rx_pkg: shared types and constants for the GPIO pixel receiver.
package gpio_rx_pkg;
  localparam int LANES = 4;
  localparam int PIX_W = 24;
  typedef enum logic [1:0] {WAIT_R, WAIT_G, WAIT_B} rx_state_t;
  // For a marker entry the processor's pixel count rides in r.
  typedef struct packed {
    logic        is_marker;
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
  } fifo_entry_t;
  function automatic logic [PIX_W-1:0] lane_pix(input fifo_entry_t e, input logic [1:0] k);
    return {e.r[8*k +: 8], e.g[8*k +: 8], e.b[8*k +: 8]};
  endfunction
endpackage

// File: rtl/gpio_rx_fifo.sv
// gpio_rx_fifo: synchronous show-ahead FIFO with full/empty and same-cycle push/pop.
// Ports: clk, rst (async, active-high), push_i/din_i write side, pop_i read side,
// dout_o head entry (valid while !empty_o), full_o/empty_o status.
module gpio_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 97
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_pop, do_push;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(do_push);
      rd_q <= rd_q + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/gpio_pixel_rx.sv
// gpio_pixel_rx: captures GPIO R/G/B/end strobes, buffers 4-pixel groups, streams pixels.
// Ports: clk, rst (async, active-high); GPIO + GPIOEnR/G/B/GPIOEn strobes in;
// pix_data/pix_valid/pix_ready stream; frame_done/frame_pixels end-of-frame report;
// err_seq/err_ovf/err_cnt sticky flags cleared by err_clr.
module gpio_pixel_rx
  import gpio_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      GPIO,
  input  logic             GPIOEnR,
  input  logic             GPIOEnG,
  input  logic             GPIOEnB,
  input  logic             GPIOEn,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             frame_done,
  output logic [31:0]      frame_pixels,
  output logic             err_seq,
  output logic             err_ovf,
  output logic             err_cnt,
  input  logic             err_clr
);
  rx_state_t   state_q, state_d;
  logic [31:0] r_q, r_d, g_q, g_d;
  fifo_entry_t push_e, head, ent_q, ent_d;
  logic        push, pop, full, empty, seq_set, ovf_set, cnt_set, multi, hs, last;
  logic        valid_q, valid_d, done_q, done_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] cnt_q, cnt_d, fpix_q, fpix_d;
  logic        err_seq_q, err_ovf_q, err_cnt_q;
  assign multi = $countones({GPIOEn, GPIOEnR, GPIOEnG, GPIOEnB}) > 1;
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    g_d     = g_q;
    push    = 1'b0;
    push_e  = '0;
    seq_set = 1'b0;
    if (multi) seq_set = 1'b1;
    else if (GPIOEn) begin
      push    = 1'b1;
      push_e  = {1'b1, GPIO, 64'd0};
      seq_set = state_q != WAIT_R;
      state_d = WAIT_R;
    end else if (GPIOEnR) begin
      // An early R restarts the group rather than being thrown away.
      seq_set = state_q != WAIT_R;
      r_d     = GPIO;
      state_d = WAIT_G;
    end else if (GPIOEnG) begin
      seq_set = state_q != WAIT_G;
      g_d     = GPIO;
      state_d = state_q == WAIT_G ? WAIT_B : WAIT_R;
    end else if (GPIOEnB) begin
      seq_set = state_q != WAIT_B;
      push    = state_q == WAIT_B;
      push_e  = {1'b0, r_q, g_q, GPIO};
      state_d = WAIT_R;
    end
  end
  gpio_rx_fifo #(.DEPTH(DEPTH), .W($bits(fifo_entry_t))) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  (push_e),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty)
  );
  assign hs   = valid_q && pix_ready;
  assign last = hs && lane_q == 2'(LANES-1);
  // Refill in the same cycle lane 3 is taken so a full FIFO streams without bubbles.
  assign pop  = !empty && (!valid_q || last);
  assign ovf_set = push && full && !pop;
  always_comb begin
    valid_d = last ? 1'b0 : valid_q;
    lane_d  = hs ? lane_q + 2'd1 : lane_q;
    ent_d   = ent_q;
    done_d  = 1'b0;
    fpix_d  = fpix_q;
    cnt_d   = cnt_q + {31'd0, hs};
    cnt_set = 1'b0;
    if (pop && head.is_marker) begin
      done_d  = 1'b1;
      fpix_d  = cnt_d;
      cnt_set = cnt_d != head.r;
      cnt_d   = '0;
    end else if (pop) begin
      ent_d   = head;
      valid_d = 1'b1;
      lane_d  = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= WAIT_R;
      r_q       <= '0;
      g_q       <= '0;
      ent_q     <= '0;
      valid_q   <= 1'b0;
      lane_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      fpix_q    <= '0;
      err_seq_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_cnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      g_q       <= g_d;
      ent_q     <= ent_d;
      valid_q   <= valid_d;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      fpix_q    <= fpix_d;
      err_seq_q <= err_clr ? 1'b0 : err_seq_q | seq_set;
      err_ovf_q <= err_clr ? 1'b0 : err_ovf_q | ovf_set;
      err_cnt_q <= err_clr ? 1'b0 : err_cnt_q | cnt_set;
    end
  assign pix_valid    = valid_q;
  assign pix_data     = valid_q ? lane_pix(ent_q, lane_q) : '0;
  assign frame_done   = done_q;
  assign frame_pixels = fpix_q;
  assign err_seq      = err_seq_q;
  assign err_ovf      = err_ovf_q;
  assign err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_gpio_pixel_rx.sv
// tb_gpio_pixel_rx: vector table, corner sequences and randomized model check for gpio_pixel_rx.
module tb_gpio_pixel_rx;
  logic        clk = 0, rst = 1, pix_ready = 0, err_clr = 0;
  logic [31:0] GPIO = 0;
  logic        en_r = 0, en_g = 0, en_b = 0, en = 0;
  logic [23:0] pix_data;
  logic        pix_valid, frame_done, err_seq, err_ovf, err_cnt;
  logic [31:0] frame_pixels;

  gpio_pixel_rx #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .GPIO(GPIO), .GPIOEnR(en_r), .GPIOEnG(en_g), .GPIOEnB(en_b),
    .GPIOEn(en), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .frame_done(frame_done), .frame_pixels(frame_pixels), .err_seq(err_seq),
    .err_ovf(err_ovf), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      r, g, b;
    logic [3:0][23:0] p;
  } vec_t;
  typedef struct packed {
    logic        fr;
    logic        mism;
    logic [31:0] val;
  } ev_t;

  vec_t        vecs [4];
  ev_t         exp_q [$];
  int          n_chk = 0, n_fail = 0, have = 0, pix_since = 0;
  logic [31:0] mr, mg;
  logic        m_seq = 0, m_cnt = 0, mon_en = 0, rnd_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix_of(input logic [31:0] r, g, b, input int k);
    return {r[8*k +: 8], g[8*k +: 8], b[8*k +: 8]};
  endfunction

  task automatic mon();
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0 || exp_q[0].fr) begin
        n_chk++; n_fail++;
        $display("FAIL rnd_pix: got unexpected pixel %0h", pix_data);
      end else begin
        chk("rnd_pix", {8'd0, pix_data}, exp_q[0].val);
        void'(exp_q.pop_front());
      end
    end
    if (frame_done) begin
      if (exp_q.size() == 0 || !exp_q[0].fr) begin
        n_chk++; n_fail++;
        $display("FAIL rnd_frame: got unexpected frame_done, frame_pixels %0d", frame_pixels);
      end else begin
        m_cnt = m_cnt | exp_q[0].mism;
        chk("rnd_frame_pixels", frame_pixels, exp_q[0].val);
        chk("rnd_err_cnt", {31'd0, err_cnt}, {31'd0, m_cnt});
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_en) mon();
    @(posedge clk);
    #1;
    if (rnd_ready) pix_ready = $urandom_range(0, 9) != 0;
  endtask

  task automatic strobe(input int ch, input logic [31:0] w);
    GPIO = w;
    en_r = ch == 0; en_g = ch == 1; en_b = ch == 2; en = ch == 3;
    tick();
    {en_r, en_g, en_b, en} = 4'd0;
  endtask

  task automatic group(input logic [31:0] r, g, b);
    strobe(0, r); strobe(1, g); strobe(2, b);
  endtask

  task automatic clear_err();
    err_clr = 1; tick(); err_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0; tick();
  endtask

  task automatic get_pixel(output logic [23:0] d, output logic ok);
    ok = 0; d = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (pix_valid) begin ok = 1; d = pix_data; end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_group(input string name, input logic [31:0] r, g, b);
    logic [23:0] d;
    logic        ok;
    for (int k = 0; k < 4; k++) begin
      get_pixel(d, ok);
      if (!ok) begin n_chk++; n_fail++; $display("FAIL %s: pixel %0d timeout", name, k); end
      else chk(name, {8'd0, d}, {8'd0, pix_of(r, g, b, k)});
    end
  endtask

  task automatic wait_frame(output logic ok, output logic [31:0] fp, output logic ec);
    ok = 0; fp = 0; ec = 0;
    for (int n = 0; n < 80 && !ok; n++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1; fp = frame_pixels; ec = err_cnt; end
      @(posedge clk); #1;
    end
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL frame_wait: got no frame_done, required one"); end
  endtask

  // Reference capture rules applied per strobe; feeds the expected-event queue.
  task automatic apply(input int ch, input logic [31:0] w);
    case (ch)
      0: begin m_seq |= have != 0; mr = w; have = 1; end
      1: if (have == 1) begin mg = w; have = 2; end else begin m_seq = 1; have = 0; end
      2: begin
        if (have == 2) begin
          for (int k = 0; k < 4; k++) exp_q.push_back('{fr: 0, mism: 0, val: {8'd0, pix_of(mr, mg, w, k)}});
          pix_since += 4;
        end else m_seq = 1;
        have = 0;
      end
      default: begin
        m_seq |= have != 0;
        exp_q.push_back('{fr: 1, mism: w != pix_since, val: pix_since});
        pix_since = 0;
        have = 0;
      end
    endcase
    strobe(ch, w);
  endtask

  initial begin
    logic        ok, ec;
    logic [31:0] fp, r, g, b;
    logic [23:0] d;
    int          v;
    vecs[0] = '{r: 32'h04030201, g: 32'h14131211, b: 32'h24232221,
                p: {24'h041424, 24'h031323, 24'h021222, 24'h011121}};
    vecs[1] = '{r: 32'hFFFFFFFF, g: 32'h00000000, b: 32'hFFFFFFFF,
                p: {24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'hFF00FF}};
    vecs[2] = '{r: 32'hA0B0C0D0, g: 32'h01020304, b: 32'h55667788,
                p: {24'hA00155, 24'hB00266, 24'hC00377, 24'hD00488}};
    vecs[3] = '{r: 32'h00000000, g: 32'hDEADBEEF, b: 32'h12345678,
                p: {24'h00DE12, 24'h00AD34, 24'h00BE56, 24'h00EF78}};

    tick(); tick();
    chk("rst_valid", {31'd0, pix_valid}, 0);
    chk("rst_data", {8'd0, pix_data}, 0);
    chk("rst_done", {31'd0, frame_done}, 0);
    chk("rst_fpix", frame_pixels, 0);
    chk("rst_errs", {29'd0, err_seq, err_ovf, err_cnt}, 0);
    rst = 0; pix_ready = 1; tick();

    // Exact latency and back-to-back lanes for each table vector.
    for (int i = 0; i < 4; i++) begin
      group(vecs[i].r, vecs[i].g, vecs[i].b);
      @(negedge clk);
      chk("lat_t1_valid", {31'd0, pix_valid}, 0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("lat_valid", {31'd0, pix_valid}, 1);
        chk("lat_pix", {8'd0, pix_data}, {8'd0, vecs[i].p[k]});
      end
      @(negedge clk);
      chk("lat_end_valid", {31'd0, pix_valid}, 0);
      @(posedge clk); #1;
    end
    chk("vec_err_seq", {31'd0, err_seq}, 0);

    // Frame accounting: matching then mismatching marker count.
    do_reset();
    group(vecs[0].r, vecs[0].g, vecs[0].b); group(vecs[2].r, vecs[2].g, vecs[2].b);
    strobe(3, 8);
    wait_frame(ok, fp, ec);
    chk("frame8_pixels", fp, 8);
    chk("frame8_err_cnt", {31'd0, ec}, 0);
    group(vecs[1].r, vecs[1].g, vecs[1].b); group(vecs[3].r, vecs[3].g, vecs[3].b);
    strobe(3, 9);
    wait_frame(ok, fp, ec);
    chk("frame9_pixels", fp, 8);
    chk("frame9_err_cnt", {31'd0, ec}, 1);
    chk("frame_err_seq", {31'd0, err_seq}, 0);

    // R then B: sequence error and no output, then recovery.
    clear_err();
    chk("clr_err_cnt", {31'd0, err_cnt}, 0);
    strobe(0, vecs[0].r); strobe(2, vecs[0].b);
    chk("rb_err_seq", {31'd0, err_seq}, 1);
    v = 0;
    repeat (6) begin @(negedge clk); if (pix_valid) v++; @(posedge clk); #1; end
    chk("rb_no_pixels", v, 0);
    group(vecs[2].r, vecs[2].g, vecs[2].b);
    check_group("rb_recover", vecs[2].r, vecs[2].g, vecs[2].b);

    // Two strobes together are ignored and leave the partial group intact.
    clear_err();
    strobe(0, vecs[3].r);
    GPIO = 32'hCAFEF00D; en_r = 1; en_g = 1; tick(); {en_r, en_g} = 2'b00;
    chk("dual_err_seq", {31'd0, err_seq}, 1);
    strobe(1, vecs[3].g); strobe(2, vecs[3].b);
    check_group("dual_keep_r", vecs[3].r, vecs[3].g, vecs[3].b);
    clear_err();
    en_r = 1; en_g = 1; err_clr = 1; tick(); {en_r, en_g, err_clr} = 3'b000;
    chk("clr_priority", {31'd0, err_seq}, 0);

    // Overflow: 10 groups with the sink stalled; the 10th is lost.
    do_reset();
    pix_ready = 0;
    for (int i = 1; i <= 10; i++) group(32'h03020100 + i * 32'h10101010, ~(32'h03020100 + i * 32'h10101010), 32'h5A5A5A5A ^ (32'h03020100 + i * 32'h10101010));
    tick(); tick();
    chk("ovf_set", {31'd0, err_ovf}, 1);
    clear_err();
    chk("ovf_clr", {31'd0, err_ovf}, 0);
    pix_ready = 1;
    v = 0;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (pix_valid) begin
        r = 32'h03020100 + (v / 4 + 1) * 32'h10101010;
        if (v < 36) chk("ovf_pix", {8'd0, pix_data}, {8'd0, pix_of(r, ~r, 32'h5A5A5A5A ^ r, v % 4)});
        v++;
      end
      @(posedge clk); #1;
    end
    chk("ovf_pix_count", v, 36);

    // Reset while a pixel is held.
    pix_ready = 0;
    strobe(2, 32'h1);
    group(vecs[1].r, vecs[1].g, vecs[1].b);
    ok = 0;
    for (int n = 0; n < 10 && !ok; n++) begin @(negedge clk); ok = pix_valid; if (!ok) begin @(posedge clk); #1; end end
    chk("rst_pre_valid", {31'd0, ok}, 1);
    chk("rst_pre_err", {31'd0, err_seq}, 1);
    rst = 1; #1;
    chk("rst_mid_valid", {31'd0, pix_valid}, 0);
    chk("rst_mid_data", {8'd0, pix_data}, 0);
    chk("rst_mid_err", {31'd0, err_seq}, 0);
    chk("rst_mid_done", {31'd0, frame_done}, 0);
    @(posedge clk); #1; rst = 0; pix_ready = 1; tick();
    group(vecs[0].r, vecs[0].g, vecs[0].b);
    check_group("rst_fresh", vecs[0].r, vecs[0].g, vecs[0].b);

    // Randomized traffic against the reference model.
    do_reset();
    have = 0; pix_since = 0; m_seq = 0; m_cnt = 0; exp_q.delete();
    rnd_ready = 1; mon_en = 1;
    for (int i = 0; i < 80; i++) begin
      v = $urandom_range(0, 9);
      if (v < 7) begin
        r = $urandom; g = $urandom; b = $urandom;
        apply(0, r); repeat ($urandom_range(0, 1)) tick();
        apply(1, g); repeat ($urandom_range(0, 1)) tick();
        apply(2, b); repeat ($urandom_range(5, 8)) tick();
      end else if (v == 7) begin
        apply($urandom_range(0, 2), $urandom); tick();
      end else begin
        apply(3, v == 8 ? pix_since : pix_since + 1 + $urandom_range(0, 5));
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    repeat (150) tick();
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_err_seq", {31'd0, err_seq}, {31'd0, m_seq});
    chk("rnd_err_cnt_final", {31'd0, err_cnt}, {31'd0, m_cnt});
    chk("rnd_err_ovf", {31'd0, err_ovf}, 0);
    mon_en = 0; rnd_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_pixel_rx.md
# gpio_pixel_rx

Board-side receiver for the processor's GPIO output port. Captures the 32-bit `GPIO` word on each channel strobe (`GPIOEnR`, `GPIOEnG`, `GPIOEnB`) and on the end-of-image strobe (`GPIOEn`). Assembles packed R/G/B words into groups of four 24-bit RGB pixels and buffers them in a group FIFO. Streams the pixels out over a valid/ready interface. The processor cannot be stalled, so the block absorbs bursts and flags every loss instead of applying back-pressure.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-high.
- `GPIO` in 32: data word from the processor.
- `GPIOEnR`, `GPIOEnG`, `GPIOEnB` in 1 each: one-cycle strobes; `GPIO` holds 4 packed 8-bit samples of that channel (byte 0 = bits 7:0 = first pixel).
- `GPIOEn` in 1: one-cycle end-of-image strobe; `GPIO` holds the processor's pixel count.
- `pix_data` out 24: pixel {R[23:16], G[15:8], B[7:0]}.
- `pix_valid` out 1 / `pix_ready` in 1: output handshake.
- `frame_done` out 1: one-cycle pulse when an end marker is retired.
- `frame_pixels` out 32: pixels transferred in the frame just closed; valid while `frame_done`=1.
- `err_seq`, `err_ovf`, `err_cnt` out 1 each: sticky error flags.
- `err_clr` in 1: synchronous clear of all three error flags.

## Operation
- Assembly FSM has three states.
  - `WAIT_R`: an R strobe latches R and moves to `WAIT_G`.
  - `WAIT_G`: a G strobe latches G and moves to `WAIT_B`.
  - `WAIT_B`: a B strobe pushes a data entry {R,G,B} and returns to `WAIT_R`.
- Out-of-order channel strobe:
  - Set `err_seq` and discard the partial group.
  - If the offending strobe is R, latch it and go to `WAIT_G`; otherwise go to `WAIT_R`.
- `GPIOEn` strobe:
  - Pushes a marker entry {count = `GPIO`} and forces the FSM to `WAIT_R`.
  - If it arrives in `WAIT_G` or `WAIT_B`, also set `err_seq` (partial group discarded).
- Two or more strobes high in one cycle: set `err_seq`, ignore all of them, leave the FSM unchanged.
- FIFO entries carry a 1-bit tag (data or marker) plus a 96-bit payload.
- Push while FIFO full: drop the entry (data or marker) and set `err_ovf`. The FSM still advances as if the push succeeded.
- Serializer:
  - Pops one entry when idle and the FIFO is non-empty.
  - Data entry: presents pixels from lane 0 to lane 3, one per accepted handshake. Lane k = {R[8k+7:8k], G[8k+7:8k], B[8k+7:8k]}.
  - Marker entry: no pixel output. Pulse `frame_done` with `frame_pixels` = pixel counter, then clear the counter. If the counter ≠ the marker count, set `err_cnt`. The marker takes one cycle.
- Pixel counter: 32 bits, increments on `pix_valid && pix_ready`, wraps at 2^32.
- `pix_data` stays stable while `pix_valid`=1 and `pix_ready`=0.
- `err_clr` takes priority over a same-cycle error set; the flag reads 0.

## Timing
- Reset values:
  - FSM `WAIT_R`, FIFO empty, serializer idle, counter 0.
  - `pix_valid`=0, `pix_data`=0, `frame_done`=0, `frame_pixels`=0, all error flags 0.
- Latency: B strobe in cycle t → FIFO written at the end of t → serializer loads at the end of t+1 → `pix_valid`=1 in cycle t+2.
- Throughput: with `pix_ready` held high, 4 pixels take 4 consecutive cycles. The next entry is loaded in the same cycle lane 3 is accepted, so there is no bubble.
- The FIFO accepts a push and a pop in the same cycle, including when full. A pop frees the slot and the push succeeds, with no `err_ovf`.
- Reset mid-frame clears everything immediately, including any held pixel. No `frame_done` is generated.

## Structure
- Package `gpio_rx_pkg`:
  - `rx_state_t` enum (`WAIT_R`, `WAIT_G`, `WAIT_B`).
  - `fifo_entry_t` packed struct {is_marker, r, g, b}; for a marker entry, the count is carried in `r`.
  - Constants `LANES`=4, `PIX_W`=24.
- Sub-module `gpio_rx_fifo`: a parameterised synchronous FIFO with full/empty flags and simultaneous push/pop. The assembly FSM and serializer stay in the top level.

## Test plan
- R=0x04030201, G=0x14131211, B=0x24232221, `pix_ready`=1 → pixels 0x011121, 0x021222, 0x031323, 0x041424 on cycles t+2..t+5.
- Two groups, then `GPIOEn` with `GPIO`=8 → 8 pixels, then `frame_done`=1 with `frame_pixels`=8 and `err_cnt`=0. Repeat with `GPIO`=9 → `err_cnt`=1.
- Sequence R,B → `err_seq`=1, no pixels. A following R,G,B still yields 4 correct pixels.
- `pix_ready`=0, DEPTH=8, 10 full groups → 8 stored (the serializer holds 1), last group dropped, `err_ovf`=1. `err_clr` → 0.
- `GPIOEnR` and `GPIOEnG` high in the same cycle → `err_seq`=1, FSM unchanged.
- `rst` asserted mid-group with `pix_valid`=1 → all outputs 0 in the same cycle. A fresh group afterwards is output correctly.
